// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } scan_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } low_hit_t;

  // valid only when exactly one column is pulled low; idx names that column.
  function automatic low_hit_t one_low(input logic [3:0] cols);
    low_hit_t hit;
    int       n_low;
    hit   = '0;
    n_low = 0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!cols[i]) begin
        n_low   = n_low + 1;
        hit.idx = 2'(i);
      end
    end
    hit.valid = (n_low == 1);
    return hit;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle pulled-up lines).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both stages sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row-at-a-time drive, single-key detection, press/release
// debounce, and one key_valid strobe per accepted physical press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 12000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    cs;
  scan_state_t   state;
  logic [1:0]    row_idx;
  logic [1:0]    lat_col;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] db_cnt;
  low_hit_t      hit;
  logic          col_only;
  logic          col_high;

  sync_2ff #(.WIDTH(NUM_COLS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols_n),
    .q     (cs)
  );

  always_comb begin
    hit      = one_low(cs);
    col_only = (cs == ~(4'b0001 << lat_col));
    col_high = cs[lat_col];
  end

  // Row drive and state freeze together; rows_n only moves when row_idx does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      lat_col   <= 2'd0;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      rows_n    <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            if (hit.valid) begin
              lat_col <= hit.idx;
              db_cnt  <= '0;
              state   <= PRESS_DB;
            end else begin
              row_idx   <= row_idx + 2'd1;
              rows_n    <= ~(4'b0001 << (row_idx + 2'd1));
              dwell_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        PRESS_DB: begin
          // A bounce on the terminal cycle wins over the accept.
          if (!col_only) begin
            dwell_cnt <= '0;
            db_cnt    <= '0;
            state     <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            key_code  <= {row_idx, lat_col};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        end
        HELD: begin
          if (col_high) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!col_high) begin
            db_cnt <= '0;
            state  <= HELD;
          end else if (db_cnt == DB_LAST) begin
            key_held  <= 1'b0;
            row_idx   <= row_idx + 2'd1;
            rows_n    <= ~(4'b0001 << (row_idx + 2'd1));
            dwell_cnt <= '0;
            state     <= SCAN;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench: physical keypad model, randomized presses, scoreboard of expected key events.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols_n;
  logic [3:0]  rows_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;   // bit r*4+c = switch at row r, column c closed

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [3:0] code;
    int         earliest;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cols_n    (cols_n),
    .rows_n    (rows_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: a closed switch pulls its column low only while its row is driven low.
  always_comb begin
    cols_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows_n[r] && pressed[r*4+c]) cols_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every key_valid strobe must match the oldest expected key event.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_key_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, mon_e.code});
        check("valid_not_early", {31'd0, cyc >= mon_e.earliest}, 32'd1);
        check("held_at_valid", {31'd0, key_held}, 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] row_drive(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  // Wait for rows_n to switch onto row r.
  task automatic wait_row(input int r, output bit ok);
    logic [3:0] prev;
    logic [3:0] tgt;
    tgt  = row_drive(r);
    prev = rows_n;
    ok   = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rows_n == tgt && prev != tgt) ok = 1'b1;
      prev = rows_n;
    end
  endtask

  task automatic wait_held(input logic lvl, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (key_held == lvl) ok = 1'b1;
    end
  endtask

  task automatic push_exp(input int r, input int c, input int earliest);
    exp_t e;
    e.code     = {r[1:0], c[1:0]};
    e.earliest = earliest;
    sb.push_back(e);
  endtask

  // Release and verify the release debounce: 2 sync + 1 detect + DEB stable cycles.
  task automatic release_and_check(input int r);
    bit ok;
    int rel;
    pressed = '0;
    rel = cyc;
    wait_held(1'b0, 100, ok);
    check("held_fall", {31'd0, ok}, 32'd1);
    check("release_latency", cyc - rel, DEB + 3);
    check("resume_row", {28'd0, rows_n}, {28'd0, row_drive((r + 1) % 4)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit         ok;
    int         c0, r, c, c2, changes, last;
    logic       held_seen, dropped;
    logic [3:0] prev;

    // Reset values.
    reset = 1'b1;
    tick(3);
    check("rst_rows_n", {28'd0, rows_n}, 32'he);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    reset = 1'b0;

    // Idle scan: each row held SCAN_DIV cycles, rotating 1110->1101->1011->0111->1110.
    prev = rows_n;
    for (int k = 0; k < 5; k++) begin
      int n;
      n = 0;
      do begin
        tick(1);
        n++;
      end while (rows_n == prev && n < 20);
      check("scan_interval", n, SCAN_DIV);
      check("scan_order", {28'd0, rows_n}, {28'd0, prev[2:0], prev[3]});
      prev = rows_n;
    end
    check("idle_held", {31'd0, key_held}, 32'd0);

    // Directed: row2/col1 pressed as row 2 comes up -> accept 8 + 20 edges later.
    wait_row(2, ok);
    check("wait_row2", {31'd0, ok}, 32'd1);
    pressed[2*4+1] = 1'b1;
    c0 = cyc;
    push_exp(2, 1, c0 + SCAN_DIV + DEB);
    wait_held(1'b1, 100, ok);
    check("held_rise", {31'd0, ok}, 32'd1);
    check("accept_latency", cyc - c0, SCAN_DIV + DEB);
    check("frozen_row2", {28'd0, rows_n}, 32'hb);
    tick(30);
    check("frozen_row2_later", {28'd0, rows_n}, 32'hb);
    release_and_check(2);
    tick(4);

    // Bounce: row0/col3 with short dropouts; accept only after DEB stable cycles.
    wait_row(0, ok);
    check("wait_row0", {31'd0, ok}, 32'd1);
    pressed[0*4+3] = 1'b1;
    last = cyc;
    for (int b = 0; b < 3; b++) begin
      tick($urandom_range(4, 12));
      pressed[0*4+3] = 1'b0;
      tick($urandom_range(1, 2));
      pressed[0*4+3] = 1'b1;
      last = cyc;
    end
    push_exp(0, 3, last + DEB);
    wait_held(1'b1, 150, ok);
    check("bounce_held_rise", {31'd0, ok}, 32'd1);
    release_and_check(0);
    tick(4);

    // Two columns low on one row: never accepted, scan keeps rotating.
    r  = $urandom_range(0, 3);
    c  = $urandom_range(0, 3);
    c2 = (c + $urandom_range(1, 3)) % 4;
    pressed[r*4+c]  = 1'b1;
    pressed[r*4+c2] = 1'b1;
    changes   = 0;
    held_seen = 1'b0;
    prev      = rows_n;
    for (int i = 0; i < 10 * SCAN_DIV; i++) begin
      tick(1);
      if (rows_n != prev) changes++;
      held_seen |= key_held;
      prev = rows_n;
    end
    check("multi_row_changes", changes, 10);
    check("multi_no_held", {31'd0, held_seen}, 32'd0);
    pressed = '0;
    tick(4);

    // Randomized single presses; odd iterations add a short release glitch while held.
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      pressed[r*4+c] = 1'b1;
      push_exp(r, c, cyc + DEB + 3);
      wait_held(1'b1, 200, ok);
      check("rand_held_rise", {31'd0, ok}, 32'd1);
      check("rand_frozen_row", {28'd0, rows_n}, {28'd0, row_drive(r)});
      tick($urandom_range(0, 20));
      if (k % 2 == 1) begin
        dropped = 1'b0;
        pressed = '0;
        for (int i = 0; i < 10; i++) begin
          tick(1);
          if (!key_held) dropped = 1'b1;
        end
        pressed[r*4+c] = 1'b1;
        for (int i = 0; i < 15; i++) begin
          tick(1);
          if (!key_held) dropped = 1'b1;
        end
        check("glitch_held_stays", {31'd0, dropped}, 32'd0);
      end
      release_and_check(r);
      tick($urandom_range(1, 10));
    end

    // Reset mid press-debounce (counter = 15): outputs return to reset, no strobe.
    wait_row(2, ok);
    check("wait_row2_rst", {31'd0, ok}, 32'd1);
    pressed[2*4+1] = 1'b1;
    tick(SCAN_DIV + 15);
    check("pre_rst_not_held", {31'd0, key_held}, 32'd0);
    reset   = 1'b1;
    pressed = '0;
    tick(1);
    check("mid_rst_rows_n", {28'd0, rows_n}, 32'he);
    check("mid_rst_key_code", {28'd0, key_code}, 32'd0);
    check("mid_rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_key_held", {31'd0, key_held}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(SCAN_DIV - 1);
    check("restart_row0", {28'd0, rows_n}, 32'he);
    tick(1);
    check("restart_row1", {28'd0, rows_n}, 32'hd);
    tick(40);
    check("post_rst_no_held", {31'd0, key_held}, 32'd0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
